// File: rtl/hex_display_driver_if.sv
// Bundles the producer-side controls and the display-side outputs of hex_display_driver.
// The producer (CPU register block or bench) uses master; the driver uses slave.
interface hex_display_driver_if #(
  parameter int NUM_DIGITS = 6
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   hexval;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      blank_lz;
  logic                      enable;
  logic [7*NUM_DIGITS-1:0]   segments;
  logic                      blink_phase;
  logic                      valid;

  modport master (
    output load, hexval, blink_mask, blank_lz, enable,
    input  segments, blink_phase, valid
  );

  modport slave (
    input  load, hexval, blink_mask, blank_lz, enable,
    output segments, blink_phase, valid
  );
endinterface

// File: rtl/hex_display_driver.sv
// Seven-segment driver: latched hex value, per-digit blinking and leading-zero
// blanking, with a registered segment output.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  hex_display_driver_if.slave  bus
);
  localparam int         CW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [4*NUM_DIGITS-1:0] r_value;
  logic                    r_valid;
  logic [CW-1:0]           r_count;
  logic                    r_phase;
  logic [7*NUM_DIGITS-1:0] r_segments;
  logic [7*NUM_DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic       w_lz;
      logic       w_blank;
      logic [6:0] w_glyph;

      // A digit is a leading zero when it and every more significant nibble are zero.
      if (gi == 0) begin : g_first
        assign w_lz = 1'b0;
      end else begin : g_upper
        assign w_lz = bus.blank_lz && (r_value[4*NUM_DIGITS-1:4*gi] == '0);
      end

      assign w_blank = !r_valid || !bus.enable ||
                       (bus.blink_mask[gi] && !r_phase) || w_lz;
      assign w_glyph = ACTIVE_LOW ? ~glyph(r_value[4*gi +: 4]) : glyph(r_value[4*gi +: 4]);
      assign w_seg_next[7*gi +: 7] = w_blank ? BLANK : w_glyph;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_phase    <= 1'b1;
      r_segments <= {NUM_DIGITS{BLANK}};
    end else begin
      if (bus.load) begin
        r_value <= bus.hexval;
        r_valid <= 1'b1;
      end
      if (r_count == CW'(BLINK_DIV - 1)) begin
        r_count <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + 1'b1;
      end
      r_segments <= w_seg_next;
    end
  end

  assign bus.segments    = r_segments;
  assign bus.blink_phase = r_phase;
  assign bus.valid       = r_valid;
endmodule

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised driver for seven-segment displays. It converts a NUM_DIGITS-nibble value into per-digit segment patterns. It adds three features to the fixed six-digit hex decoder: a registered load strobe, per-digit blinking, and leading-zero blanking. It sits between a CPU-facing register block (or any producer) and the board's HEX display pins.

## Interface
- NUM_DIGITS, 6: number of 4-bit digits driven; legal range 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period; minimum 2.
- ACTIVE_LOW, 1: 1 means a lit segment drives 0 (DE1-SoC HEX pins); 0 means a lit segment drives 1.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- load  in  1  when high at a rising edge, hexval is captured into the value register.
- hexval  in  4*NUM_DIGITS  value to display; nibble i maps to digit i (digit 0 is least significant, rightmost).
- blink_mask  in  NUM_DIGITS  bit i set means digit i blinks; sampled every cycle, not latched.
- blank_lz  in  1  enables leading-zero blanking; sampled every cycle.
- enable  in  1  0 blanks every digit; sampled every cycle.
- segments  out  7*NUM_DIGITS  segments[7i+6:7i] drive digit i; bit 0 is segment a through bit 6 is segment g.
- blink_phase  out  1  current blink phase; 1 means blinking digits are lit.
- valid  out  1  high once at least one load has occurred since reset.

## Operation
- **Value register** (4*NUM_DIGITS bits). Reset value 0. On a rising edge with load=1 it takes hexval. When load is held high, the register captures hexval on every edge.
- **valid flag.** Reset value 0. Set on the first load edge. It stays set until reset.
- **Blink counter.** Width is ceil(log2(BLINK_DIV)). Reset value 0. It increments every cycle.
  - When the counter equals BLINK_DIV-1, it wraps to 0 and blink_phase toggles in the same edge.
  - blink_phase resets to 1.
  - The counter runs regardless of enable, load and valid.
- **Glyph table** (active-high patterns, g..a):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
  - When ACTIVE_LOW=1, each pattern is bitwise inverted. A blank digit is all segments unlit: 0x7F when ACTIVE_LOW=1, 0x00 otherwise.
- **Blanking.** Digit i is blank when any of the following holds:
  - valid=0
  - enable=0
  - blink_mask[i]=1 and blink_phase=0
  - blank_lz=1, i>0, and every nibble from i up to NUM_DIGITS-1 is zero
- **Digit 0** is never subject to leading-zero blanking. A value of 0 with blank_lz=1 therefore displays a single "0".
- **Output register.** segments is registered. The next value is computed from the value register, valid, blink_phase, and the live blink_mask/blank_lz/enable.

## Timing
- **Reset.** Asynchronous reset forces the following immediately, without a clock edge:
  - segments = all-blank (all 1s when ACTIVE_LOW=1)
  - blink_phase = 1, valid = 0, value register = 0, counter = 0
- **Reset release.** The first active edge follows normal rules. Reset asserted mid-operation (mid-blink, or in the same cycle as load) discards the load and blanks the outputs at once.
- **Load latency.** load sampled at edge n updates the value register at edge n. segments reflects the new value after edge n+1. valid also rises at edge n, so the first load appears after edge n+1.
- **Control latency.** blink_mask, blank_lz and enable changes sampled at edge n appear on segments after edge n.
- **Blink latency.** A blink_phase toggle at edge n appears on segments after edge n+1.
- **Blink period.** The blink half-period is exactly BLINK_DIV cycles; the full period is 2*BLINK_DIV.
- **Simultaneous events.** load, a blink toggle and control changes in the same cycle are all honoured, each with the latency above. No event blocks another.
- **Handshake.** There is no ready or backpressure; load is accepted in every cycle.

## Test plan
Bench configuration: NUM_DIGITS=6, ACTIVE_LOW=1, BLINK_DIV=4.

1. **Reset state.** Assert reset with no clock edge, then release. Required: segments=42'h3FF_FFFF_FFFF, blink_phase=1, valid=0. Then clock 10 cycles with load=0. Required: segments stays all 1s.
2. **Load and latency.** Pulse load for one cycle with hexval=24'h12AB3F and enable=1. Required: after the load edge, valid=1 and segments is unchanged. After the next edge: digit0=7'h0E (F), digit1=7'h30 (3), digit2=7'h03 (b), digit3=7'h08 (A), digit4=7'h24 (2), digit5=7'h79 (1).
3. **Leading-zero blanking.**
   - Set blank_lz=1 and load 24'h000A05. Required: digits 5..3 = 7'h7F, digit2=7'h08, digit1=7'h40, digit0=7'h12.
   - Load 24'h000000. Required: only digit0=7'h40; all others 7'h7F.
4. **Blink.** Set blink_mask=6'b000001 with value 24'h12AB3F loaded. Required: blink_phase toggles every 4 cycles. digit0 alternates between 7'h0E and 7'h7F in 4-cycle runs, one edge behind blink_phase. Digits 1..5 stay steady.
5. **Reset mid-blink.** Assert reset while blink_phase=0 and load=1 in the same cycle. Required: segments goes all 1s immediately, blink_phase=1, valid=0. After release, the dropped load value is never displayed.
6. **Enable gating.** Set enable=0 for 3 cycles, then back to 1. Required: all digits read 7'h7F one edge after enable falls, and the previous value returns one edge after enable rises. The blink counter cadence is unaffected.
